// File: rtl/envia_mensage.sv
// Sends a ROM-held message one character at a time over a valid/ready link.
// Each character is sampled after a programmable ROM settle time.
module envia_mensage #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       aceito,
  input  logic       comprometido,
  input  logic       rejeitado,
  input  logic [3:0] caracter,
  input  logic [3:0] len_string,
  output logic [3:0] counter_caracter,
  output logic       sel_aceito,
  output logic       sel_comprometido,
  output logic       sel_rejeitado,
  output logic [3:0] char_out,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       busy,
  output logic       done,
  output logic       erro,
  output logic [2:0] dbg_state
);

  // Handshake: char_out/char_valid are held stable from the cycle char_valid
  // rises until a rising edge sees char_valid && char_ready (the transfer);
  // char_ready is ignored while char_valid is low.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_SEND   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] len_q, len_d;
  logic [2:0] settle_q, settle_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] char_q, char_d;
  logic       valid_q, valid_d;
  logic       erro_q, erro_d;
  logic       flags_ok;
  logic       last_char;

  // Exactly one status flag must be high for a start to be accepted.
  always_comb begin
    flags_ok = 1'b0;
    case ({aceito, comprometido, rejeitado})
      3'b100, 3'b010, 3'b001: flags_ok = 1'b1;
      default:                flags_ok = 1'b0;
    endcase
  end

  assign last_char = (cnt_q == (len_q - 4'd1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    settle_d = settle_q;
    sel_d    = sel_q;
    char_d   = char_q;
    valid_d  = valid_q;
    erro_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (flags_ok) begin
            sel_d   = {aceito, comprometido, rejeitado};
            cnt_d   = 4'd0;
            state_d = S_LOAD;
          end else begin
            erro_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        len_d    = len_string;
        settle_d = 3'd0;
        state_d  = (len_string == 4'd0) ? S_DONE : S_SETTLE;
      end

      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          char_d   = caracter;
          valid_d  = 1'b1;
          settle_d = 3'd0;
          state_d  = S_SEND;
        end else begin
          settle_d = settle_q + 3'd1;
        end
      end

      S_SEND: begin
        if (valid_q && char_ready) begin
          valid_d = 1'b0;
          if (last_char) begin
            state_d = S_DONE;
          end else begin
            cnt_d    = cnt_q + 4'd1;
            settle_d = 3'd0;
            state_d  = S_SETTLE;
          end
        end
      end

      S_DONE: begin
        sel_d   = 3'b000;
        cnt_d   = 4'd0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      len_q    <= 4'd0;
      settle_q <= 3'd0;
      sel_q    <= 3'b000;
      char_q   <= 4'd0;
      valid_q  <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      settle_q <= settle_d;
      sel_q    <= sel_d;
      char_q   <= char_d;
      valid_q  <= valid_d;
      erro_q   <= erro_d;
    end
  end

  assign counter_caracter = cnt_q;
  assign sel_aceito       = sel_q[2];
  assign sel_comprometido = sel_q[1];
  assign sel_rejeitado    = sel_q[0];
  assign char_out         = char_q;
  assign char_valid       = valid_q;
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);
  assign erro             = erro_q;
  assign dbg_state        = state_q;

endmodule

// File: doc/envia_mensage.md
ENVIA_MENSAGE -- requirements
Module: envia_mensage

Interface
REQ-001 Parameter SETTLE, default 1, ROM settle cycles after each counter_caracter change before caracter is sampled (legal range 1..7).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to send the message selected by the status inputs.
REQ-005 aceito, comprometido, rejeitado  input  1 each  status flags, sampled only on an accepted start; exactly one high is valid.
REQ-006 caracter  input  4  character code returned by the message ROM for counter_caracter.
REQ-007 len_string  input  4  length of the selected message (0..15).
REQ-008 counter_caracter  output  4  character index presented to the message ROM.
REQ-009 sel_aceito, sel_comprometido, sel_rejeitado  output  1 each  latched status driven to the message ROM selector.
REQ-010 char_out  output  4  character presented to the display.
REQ-011 char_valid  output  1  char_out valid; a transfer occurs when char_valid and char_ready are both high on a rising edge.
REQ-012 char_ready  input  1  display accepts char_out.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse after the last character transfer (or after an empty message).
REQ-015 erro  output  1  one-cycle pulse on a rejected start.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, SETTLE, SEND, DONE.
REQ-017 IDLE: start with exactly one status flag high -> latch flags into sel_*, counter_caracter=0, go LOAD next cycle.
REQ-018 IDLE: start with zero or more than one flag high -> erro=1 the next cycle for one cycle, sel_* unchanged (0), remain IDLE.
REQ-019 start SHALL be ignored in every state other than IDLE (no erro, no restart).
REQ-020 LOAD (1 cycle): capture len_string into an internal length register; length 0 -> DONE, else -> SETTLE.
REQ-021 SETTLE: hold counter_caracter for SETTLE cycles, then load caracter into char_out, set char_valid=1, go SEND.
REQ-022 SEND: char_out and char_valid SHALL stay stable until the transfer; char_ready low stalls indefinitely.
REQ-023 On transfer with counter_caracter == length-1: char_valid=0 next cycle, go DONE.
REQ-024 On transfer otherwise: char_valid=0, counter_caracter increments by 1, go SETTLE.
REQ-025 counter_caracter SHALL never wrap; maximum value 14 (length 15).
REQ-026 Length is latched once in LOAD; len_string changes during the message SHALL have no effect.
REQ-027 DONE (1 cycle): done=1, sel_* cleared to 0, counter_caracter=0, go IDLE; start in DONE is ignored.
REQ-028 Status-flag changes after the accepted start SHALL have no effect until the next accepted start.
REQ-029 char_ready while char_valid is low SHALL be ignored.
REQ-030 Characters SHALL be delivered in index order 0..length-1, each exactly once.

Reset
REQ-031 reset high on a rising edge SHALL force IDLE and all outputs to 0 (counter_caracter, sel_*, char_out, char_valid, busy, done, erro), overriding start.
REQ-032 reset mid-message SHALL abort without a done pulse; a later start begins a fresh message from index 0.
REQ-033 The internal length and settle counters SHALL reset to 0.

Verification
REQ-034 aceito=1, start pulse, len_string=3, ROM codes 0xA,0xB,0xC, char_ready=1 constant -> char_out sequence A,B,C, each with SETTLE cycles between transfers; done pulses once; busy falls with done.
REQ-035 rejeitado=1, len_string=5, char_ready toggled low for 4 cycles at index 2 -> char_out=code[2] held stable during stall; 5 transfers total; done once.
REQ-036 start with aceito=1 and comprometido=1 (and separately with all flags 0) -> erro pulses 1 cycle, busy stays 0, no char_valid.
REQ-037 comprometido=1, len_string=0 -> busy for LOAD and DONE only, done pulses, char_valid never asserted.
REQ-038 reset asserted during SEND at index 1 of a 4-char message -> all outputs 0 the next cycle, no done; following start sends from index 0.
REQ-039 start pulsed again during SEND, and len_string changed from 4 to 9 mid-message -> ignored; exactly 4 characters sent.
